// File: rtl/text_typewriter.sv
// Typewriter writer: copies msg_len ROM characters into the text buffer, one per CHAR_DELAY frames.
// Optional feature macro TYPEWRITER_CLEAR_EN: fill the buffer with spaces before typing.
module text_typewriter #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int CHAR_DELAY = 2,
    parameter int ADDR_W     = 12
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [7:0]        msg_base,
    input  logic [5:0]        msg_len,
    input  logic [4:0]        row,
    input  logic [6:0]        col,
    input  logic              frame_tick,
    output logic [7:0]        rom_addr,
    input  logic [7:0]        rom_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done
);
    localparam int DW = (CHAR_DELAY > 1) ? $clog2(CHAR_DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef TYPEWRITER_CLEAR_EN
        S_CLEAR,
`endif
        S_FETCH,
        S_ROMWAIT,
        S_WRITE,
        S_DELAY,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    state_t            w_post;
    logic [7:0]        r_base;
    logic [5:0]        r_len;
    logic [5:0]        r_idx;
    logic [4:0]        r_row;
    logic [6:0]        r_col;
    logic [6:0]        r_col0;
    logic [DW-1:0]     r_dly;
    logic [7:0]        r_wr_data;
    logic [4:0]        w_row_in;
    logic [6:0]        w_col_in;
    logic [4:0]        w_row_inc;
    logic              w_last;
    logic              w_newline;
    logic [ADDR_W-1:0] w_cur_addr;
`ifdef TYPEWRITER_CLEAR_EN
    logic [ADDR_W-1:0] r_clr;
`endif

    assign w_row_in   = (int'(row) < ROWS) ? row : '0;
    assign w_col_in   = (int'(col) < COLS) ? col : '0;
    assign w_row_inc  = (r_row == 5'(ROWS - 1)) ? '0 : r_row + 5'd1;
    assign w_last     = (r_idx == r_len - 6'd1);
    assign w_newline  = (rom_data == 8'h0A);
    assign w_cur_addr = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Newline skips the frame delay, so its post path differs from a real write.
    always_comb begin
        w_post = S_DONE;
        if (!w_last) begin
            if (CHAR_DELAY == 0 || (r_state == S_ROMWAIT)) begin
                w_post = S_FETCH;
            end else begin
                w_post = S_DELAY;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (msg_len == '0) begin
                        w_next = S_DONE;
                    end else begin
`ifdef TYPEWRITER_CLEAR_EN
                        w_next = S_CLEAR;
`else
                        w_next = S_FETCH;
`endif
                    end
                end
            end
`ifdef TYPEWRITER_CLEAR_EN
            S_CLEAR: begin
                if (wr_ready && (r_clr == ADDR_W'(ROWS * COLS - 1))) begin
                    w_next = S_FETCH;
                end
            end
`endif
            S_FETCH:   w_next = S_ROMWAIT;
            S_ROMWAIT: w_next = w_newline ? w_post : S_WRITE;
            S_WRITE: begin
                if (wr_ready) begin
                    w_next = w_post;
                end
            end
            S_DELAY: begin
                if (frame_tick && (r_dly == DW'(CHAR_DELAY - 1))) begin
                    w_next = S_FETCH;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_base    <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_col0    <= '0;
            r_dly     <= '0;
            r_wr_data <= '0;
`ifdef TYPEWRITER_CLEAR_EN
            r_clr     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base <= msg_base;
                        r_len  <= msg_len;
                        r_row  <= w_row_in;
                        r_col  <= w_col_in;
                        r_col0 <= w_col_in;
                        r_idx  <= '0;
`ifdef TYPEWRITER_CLEAR_EN
                        r_clr  <= '0;
`endif
                    end
                end
`ifdef TYPEWRITER_CLEAR_EN
                S_CLEAR: begin
                    if (wr_ready) begin
                        r_clr <= r_clr + 1'b1;
                    end
                end
`endif
                S_ROMWAIT: begin
                    r_wr_data <= rom_data;
                    if (w_newline) begin
                        r_row <= w_row_inc;
                        r_col <= r_col0;
                        r_idx <= r_idx + 6'd1;
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        if (r_col == 7'(COLS - 1)) begin
                            r_col <= '0;
                            r_row <= w_row_inc;
                        end else begin
                            r_col <= r_col + 7'd1;
                        end
                        r_idx <= r_idx + 6'd1;
                        r_dly <= '0;
                    end
                end
                S_DELAY: begin
                    if (frame_tick) begin
                        r_dly <= r_dly + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr = r_base + {2'b00, r_idx};
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

`ifdef TYPEWRITER_CLEAR_EN
    assign wr_en   = (r_state == S_WRITE) || (r_state == S_CLEAR);
    assign wr_addr = (r_state == S_CLEAR) ? r_clr : w_cur_addr;
    assign wr_data = (r_state == S_CLEAR) ? 8'h20 : r_wr_data;
`else
    assign wr_en   = (r_state == S_WRITE);
    assign wr_addr = w_cur_addr;
    assign wr_data = r_wr_data;
`endif

endmodule
